// File: rtl/change_dispenser.sv
// Change dispenser: pays a latched amount out as single-coin eject pulses from
// three coin tubes, greedy largest-first, limited by what each tube still holds.
module change_dispenser #(
    parameter int DEN_A  = 10,
    parameter int DEN_B  = 5,
    parameter int DEN_C  = 1,
    parameter int INIT_A = 20,
    parameter int INIT_B = 20,
    parameter int INIT_C = 50,
    parameter int GAP    = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] amount,
    input  logic        refill,
    output logic        busy,
    output logic        eject_a,
    output logic        eject_b,
    output logic        eject_c,
    output logic [31:0] remaining,
    output logic        done,
    output logic [31:0] shortfall,
    output logic [15:0] cnt_a,
    output logic [15:0] cnt_b,
    output logic [15:0] cnt_c,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        EJECT  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [31:0] VAL_A  = 32'(DEN_A);
    localparam logic [31:0] VAL_B  = 32'(DEN_B);
    localparam logic [31:0] VAL_C  = 32'(DEN_C);
    localparam logic [15:0] FULL_A = 16'(INIT_A);
    localparam logic [15:0] FULL_B = 16'(INIT_B);
    localparam logic [15:0] FULL_C = 16'(INIT_C);
    localparam logic [15:0] GAP_M1 = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    state_t      state;
    logic [1:0]  sel;
    logic [15:0] gap_cnt;
    logic        can_a;
    logic        can_b;
    logic        can_c;

    // A tube qualifies only if it can pay without overshooting and is not empty.
    assign can_a = (remaining >= VAL_A) && (cnt_a != 16'd0);
    assign can_b = (remaining >= VAL_B) && (cnt_b != 16'd0);
    assign can_c = (remaining >= VAL_C) && (cnt_c != 16'd0);

    assign fsm_state = state;

    // Request handshake: start is a one-cycle strobe accepted only while idle
    // (busy low); while busy, start and refill are ignored and never queued.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            sel       <= SEL_A;
            gap_cnt   <= 16'd0;
            busy      <= 1'b0;
            eject_a   <= 1'b0;
            eject_b   <= 1'b0;
            eject_c   <= 1'b0;
            done      <= 1'b0;
            remaining <= 32'd0;
            shortfall <= 32'd0;
            cnt_a     <= FULL_A;
            cnt_b     <= FULL_B;
            cnt_c     <= FULL_C;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= amount;
                        shortfall <= 32'd0;
                        busy      <= 1'b1;
                        state     <= SELECT;
                    end else if (refill) begin
                        cnt_a <= FULL_A;
                        cnt_b <= FULL_B;
                        cnt_c <= FULL_C;
                    end
                end

                SELECT: begin
                    if (remaining != 32'd0 && can_a) begin
                        sel     <= SEL_A;
                        eject_a <= 1'b1;
                        state   <= EJECT;
                    end else if (remaining != 32'd0 && can_b) begin
                        sel     <= SEL_B;
                        eject_b <= 1'b1;
                        state   <= EJECT;
                    end else if (remaining != 32'd0 && can_c) begin
                        sel     <= SEL_C;
                        eject_c <= 1'b1;
                        state   <= EJECT;
                    end else begin
                        done      <= 1'b1;
                        shortfall <= remaining;
                        state     <= FINISH;
                    end
                end

                EJECT: begin
                    eject_a <= 1'b0;
                    eject_b <= 1'b0;
                    eject_c <= 1'b0;
                    case (sel)
                        SEL_A: begin
                            cnt_a     <= cnt_a - 16'd1;
                            remaining <= remaining - VAL_A;
                        end
                        SEL_B: begin
                            cnt_b     <= cnt_b - 16'd1;
                            remaining <= remaining - VAL_B;
                        end
                        default: begin
                            cnt_c     <= cnt_c - 16'd1;
                            remaining <= remaining - VAL_C;
                        end
                    endcase
                    if (GAP > 0) begin
                        gap_cnt <= GAP_M1;
                        state   <= WAIT;
                    end else begin
                        state <= SELECT;
                    end
                end

                WAIT: begin
                    if (gap_cnt == 16'd0) begin
                        state <= SELECT;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end

                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
